ro_pair_meas_ctrl: RTL and testbench
====================================

Name: ro_pair_meas_ctrl

Overview:
Measurement controller for the ring-oscillator PUF array. For each challenge, it selects two oscillators, enables only that pair, and lets them settle. It then counts their rising edges over a fixed window of system clocks and compares the two counts to produce one response bit. It sits between the challenge source (UART/serial front end) and the bank of ring_osc instances, and it owns every RO enable line.

Parameters:
- N_RO, 16: number of ring oscillators in the bank; power of two, at least 2.
- SEL_W, $clog2(N_RO): width of one oscillator index.
- CNT_W, 16: edge-counter width.
- WIN_CYCLES, 4096: measurement window length in clk cycles; at least 1.
- SETTLE_CYCLES, 8: clk cycles between enabling the pair and starting to count; at least 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to measure; sampled only in IDLE.
- challenge, input, 2*SEL_W: [2*SEL_W-1:SEL_W] is index A, [SEL_W-1:0] is index B; captured when start is accepted.
- ro_out, input, N_RO: raw oscillator outputs; asynchronous to clk.
- ro_en, output, N_RO: per-oscillator enable.
- busy, output, 1: high from the cycle after start is accepted through the done cycle.
- done, output, 1: one-cycle pulse when the result is valid.
- response, output, 1: PUF bit; held until the next accepted start.
- err, output, 1: set on done when A equals B; held like response.
- cnt_a, output, CNT_W: final count for oscillator A; held.
- cnt_b, output, CNT_W: final count for oscillator B; held.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - ro_en=0, busy=0, done=0, response=0, err=0, cnt_a=0, cnt_b=0.
  - All synchronizer and edge flops cleared.
  - Reset in the middle of a measurement drops ro_en in the same instant. No done pulse follows.
- FSM states: IDLE, SETTLE, COUNT, DRAIN, CMP, DONE.
- IDLE:
  - When start=1: capture idx_a and idx_b, load the timer, go to SETTLE.
  - If idx_a==idx_b: skip straight to DONE with err=1, response=0, counts=0. ro_en is never asserted.
- SETTLE:
  - ro_en[idx_a] and ro_en[idx_b] are set; all other enable bits are 0.
  - Counters held at 0.
  - Stay SETTLE_CYCLES cycles, then go to COUNT.
- COUNT:
  - Each selected ro_out passes through a 2-flop synchronizer plus an edge-detect flop.
  - Each synchronized rising edge increments that side's counter.
  - Stay exactly WIN_CYCLES cycles, then go to DRAIN.
- DRAIN:
  - ro_en cleared on entry.
  - Counting stops; edges still in the synchronizer are discarded.
  - Lasts 1 cycle, then CMP.
- CMP:
  - response = (cnt_a > cnt_b), err = 0.
  - cnt_a and cnt_b are registered to the outputs.
  - Then DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. busy=0 in IDLE.
- Counters saturate at 2^CNT_W-1 and do not wrap. If both saturate, they are equal, so response=0.
- Equal counts give response=0.
- start is ignored while busy=1, including in the DONE cycle.
- The challenge is captured only at accept; later changes have no effect on the running measurement.
- Oscillator frequency must be below clk/2 for the edge count to be exact. This is a system constraint and is not checked in RTL.
- Latency from start to done: SETTLE_CYCLES + WIN_CYCLES + 3 cycles. For the A==B error case: 1 cycle.

Optional Feature:
- Macro: ROPUF_TIE_FLAG_EN.
- Defined: adds output port tie (1 bit).
  - Set in CMP when cnt_a==cnt_b and A!=B; cleared otherwise. Held like response; reset value 0.
  - With tie=1, response is still 0.
- Undefined: no tie port; equal counts are indistinguishable from A slower than B.

Decomposition:
- Package ro_puf_pkg:
  - state enum meas_state_e.
  - Default parameter constants.
  - Function sat_inc(cnt) for the saturating increment.
- Sub-module ro_edge_counter, instantiated twice (A and B):
  - Inputs: clk, rst_n, clr, cnt_en, ro_in.
  - Contents: 2-flop synchronizer, edge-detect flop, saturating CNT_W counter.
  - The top level muxes ro_out[idx] into it.

Test Plan:
- Ideal clocks: RO A modelled at clk/4, RO B at clk/5, WIN_CYCLES=100, challenge A=3, B=7 -> done after SETTLE+103 cycles; cnt_a=25±1, cnt_b=20±1, response=1, err=0; only ro_en[3] and ro_en[7] high during SETTLE/COUNT.
- Same frequencies, challenge swapped (A=7, B=3) -> response=0; counts mirrored.
- Challenge A=B=5 -> done on the cycle after start, err=1, response=0, ro_en never asserted.
- Saturation: CNT_W=4, both ROs at clk/3, WIN_CYCLES=100 -> cnt_a=cnt_b=15, response=0; tie=1 when ROPUF_TIE_FLAG_EN is defined.
- Pulse start every cycle during a measurement and change challenge mid-COUNT -> exactly one done per accepted start; result matches the originally captured indices.
- Drop rst_n mid-COUNT -> ro_en=0 asynchronously, no done; a subsequent start runs a clean measurement with correct counts.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the RO-PUF pair measurement controller.
package ro_puf_pkg;

    localparam int DEF_N_RO          = 16;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_WIN_CYCLES    = 4096;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DRAIN,
        ST_CMP,
        ST_DONE
    } meas_state_e;

    // Increment that sticks at the all-ones value of a w-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (cnt >= max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one raw oscillator output and counts its rising edges.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] cnt
);

    logic             s1_q;
    logic             s2_q;
    logic             edge_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            edge_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= ro_in;
            s2_q   <= s1_q;
            edge_q <= s2_q;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && s2_q && !edge_q) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ro_pair_meas_ctrl.sv
// RO pair measurement FSM: settle, count a window, compare, report.
// Optional tie output when ROPUF_TIE_FLAG_EN is defined.
module ro_pair_meas_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_RO          = DEF_N_RO,
    parameter int SEL_W         = $clog2(N_RO),
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [N_RO-1:0]    ro_out,
    output logic [N_RO-1:0]    ro_en,
    output logic               busy,
    output logic               done,
    output logic               response,
    output logic               err,
`ifdef ROPUF_TIE_FLAG_EN
    output logic               tie,
`endif
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);

    localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ?
                             WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    meas_state_e      state_q, state_d;
    logic [SEL_W-1:0] idx_a_q, idx_a_d;
    logic [SEL_W-1:0] idx_b_q, idx_b_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             resp_q, resp_d;
    logic             err_q, err_d;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0] raw_a, raw_b;
    logic [SEL_W-1:0] ch_a, ch_b;

    assign ch_a = challenge[2*SEL_W-1:SEL_W];
    assign ch_b = challenge[SEL_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_a_q <= '0;
            idx_b_q <= '0;
            tmr_q   <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            tie_q   <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            tmr_q   <= tmr_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            tie_q   <= tie_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_a_d = idx_a_q;
        idx_b_d = idx_b_q;
        tmr_d   = tmr_q;
        resp_d  = resp_q;
        err_d   = err_q;
        tie_d   = tie_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_a_d = ch_a;
                    idx_b_d = ch_b;
                    tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                    // A self-paired challenge has no meaningful bit
                    if (ch_a == ch_b) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        resp_d  = 1'b0;
                        tie_d   = 1'b0;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = ST_COUNT;
                    tmr_d   = TMR_W'(WIN_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_COUNT: begin
                if (tmr_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_CMP;
            ST_CMP: begin
                resp_d  = raw_a > raw_b;
                tie_d   = raw_a == raw_b;
                err_d   = 1'b0;
                cnt_a_d = raw_a;
                cnt_b_d = raw_b;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ro_en = '0;
        if (state_q == ST_SETTLE || state_q == ST_COUNT) begin
            ro_en[idx_a_q] = 1'b1;
            ro_en[idx_b_q] = 1'b1;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == ST_SETTLE),
        .cnt_en (state_q == ST_COUNT),
        .ro_in  (ro_out[idx_a_q]),
        .cnt    (raw_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == ST_SETTLE),
        .cnt_en (state_q == ST_COUNT),
        .ro_in  (ro_out[idx_b_q]),
        .cnt    (raw_b)
    );

    assign busy     = state_q != ST_IDLE;
    assign done     = state_q == ST_DONE;
    assign response = resp_q;
    assign err      = err_q;
    assign cnt_a    = cnt_a_q;
    assign cnt_b    = cnt_b_q;
`ifdef ROPUF_TIE_FLAG_EN
    assign tie      = tie_q;
`else
    logic unused_tie;
    assign unused_tie = tie_q;
`endif

endmodule

// File: tb/tb_ro_pair_meas_ctrl.sv
// Scoreboard bench for ro_pair_meas_ctrl with free-running ideal ROs.
`timescale 1ns/1ps
module tb_ro_pair_meas_ctrl;

    localparam int NR  = 16;
    localparam int CW  = 5;
    localparam int WIN = 100;
    localparam int SET = 8;
    localparam int SATV = (1 << CW) - 1;
    // RO periods in ns; clk period is 10 ns
    localparam int PER [NR] = '{30, 70, 100, 40, 100, 70, 50, 50,
                                40, 70, 30, 100, 40, 50, 70, 30};

    typedef struct {
        int   a;
        int   b;
        int   k;
        logic e;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    challenge;
    logic [NR-1:0] ro_out;
    logic [NR-1:0] ro_en;
    logic          busy;
    logic          done;
    logic          response;
    logic          err;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
`ifdef ROPUF_TIE_FLAG_EN
    logic          tie;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q[$];
    logic en_bad  = 1'b0;

    ro_pair_meas_ctrl #(
        .N_RO(NR), .CNT_W(CW), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .challenge (challenge),
        .ro_out    (ro_out),
        .ro_en     (ro_en),
        .busy      (busy),
        .done      (done),
        .response  (response),
        .err       (err),
`ifdef ROPUF_TIE_FLAG_EN
        .tie       (tie),
`endif
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NR; g++) begin : g_ro
        logic r;
        initial begin
            r = 1'b0;
            #($urandom_range(1, 49) * 0.1);
            forever #(PER[g] / 2.0) r = ~r;
        end
        assign ro_out[g] = r;
    end

    task automatic chk(string nm, int act, int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_rng(string nm, int act, int lo, int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic real ideal(int i);
        return WIN * 10.0 / PER[i];
    endfunction

    task automatic chk_cnt(string nm, int act, int i);
        real x;
        int  lo, hi;
        x = ideal(i);
        if (x - 1.0 > SATV) begin
            chk(nm, act, SATV);
        end else begin
            lo = int'($floor(x)) - 1;
            hi = int'($ceil(x)) + 1;
            if (hi > SATV) hi = SATV;
            chk_rng(nm, act, lo, hi);
        end
    endtask

    // Monitor: ro_en tracking each cycle, full result check on every done
    logic [NR-1:0] m;
    int            d;
    exp_t          it;
    real           ea, eb;
    always @(negedge clk) begin
        m = '0;
        if (q.size() > 0 && !q[0].e) begin
            d = cyc - q[0].k;
            if (d >= 1 && d <= SET + WIN) begin
                m[q[0].a] = 1'b1;
                m[q[0].b] = 1'b1;
            end
        end
        if (rst_n && ro_en !== m) en_bad = 1'b1;
        if (done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                it = q.pop_front();
                chk("latency", cyc - it.k, it.e ? 1 : SET + WIN + 3);
                chk("busy_at_done", int'(busy), 1);
                chk("ro_en_pair", int'(en_bad), 0);
                en_bad = 1'b0;
                if (it.e) begin
                    chk("err_same", int'(err), 1);
                    chk("resp_same", int'(response), 0);
                    chk("cnt_a_same", int'(cnt_a), 0);
                    chk("cnt_b_same", int'(cnt_b), 0);
`ifdef ROPUF_TIE_FLAG_EN
                    chk("tie_same", int'(tie), 0);
`endif
                end else begin
                    ea = ideal(it.a) > SATV ? SATV : ideal(it.a);
                    eb = ideal(it.b) > SATV ? SATV : ideal(it.b);
                    chk("err", int'(err), 0);
                    chk_cnt("cnt_a", int'(cnt_a), it.a);
                    chk_cnt("cnt_b", int'(cnt_b), it.b);
                    chk("response", int'(response), (ea > eb) ? 1 : 0);
`ifdef ROPUF_TIE_FLAG_EN
                    chk("tie", int'(tie), (ea == eb) ? 1 : 0);
`endif
                end
            end
        end
    end

    task automatic issue(int a, int b);
        int g;
        g = 0;
        while (busy && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", g);
        end
        challenge = {4'(a), 4'(b)};
        start     = 1'b1;
        q.push_back('{a: a, b: b, k: cyc, e: (a == b)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_meas(int a, int b, bit spam);
        int g;
        issue(a, b);
        g = 0;
        while (busy && g < 1000) begin
            if (spam) begin
                start     = 1'($urandom_range(0, 1));
                challenge = 8'($urandom);
            end
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        if (g >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy after %0d cycles expected idle", g);
        end
    endtask

    task automatic reset_mid(int a, int b);
        issue(a, b);
        repeat (SET + 40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ro_en", int'(ro_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        q.delete();
        en_bad = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cnt_a", int'(cnt_a), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_meas(a, b, 1'b0);
    endtask

    initial begin
        int a, b, g;
        rst_n     = 1'b0;
        start     = 1'b0;
        challenge = '0;
        repeat (3) @(negedge clk);
        chk("reset_ro_en", int'(ro_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_resp", int'(response), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);
        chk("reset_cnt_b", int'(cnt_b), 0);
`ifdef ROPUF_TIE_FLAG_EN
        chk("reset_tie", int'(tie), 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_meas(3, 7, 1'b0);
        do_meas(7, 3, 1'b0);
        do_meas(5, 5, 1'b0);
        do_meas(0, 10, 1'b0);
        do_meas(3, 7, 1'b1);
        reset_mid(7, 3);

        for (int i = 0; i < 25; i++) begin
            a = $urandom_range(0, NR - 1);
            b = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 5) == 0) begin
                b = a;
            end else begin
                while (b == a || (PER[a] == PER[b] && PER[a] != 30))
                    b = $urandom_range(0, NR - 1);
            end
            do_meas(a, b, 1'($urandom_range(0, 1)));
        end

        g = 0;
        while ((q.size() > 0 || busy) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
